baser_257b_generator: RTL and testbench
=======================================

Name: baser_257b_generator

Overview:
- Transmit-side traffic source for the BASE-R 257b path. It is the stimulus end of the 257b transcoded link that the team's 257b checker monitors.
- Internally runs a 64b block sequencer (idle, start, data, terminate) and emits four 64b blocks per cycle.
- Transcodes each group of four into one 257b block per Clause 91 rules and presents it on a valid/ready interface.
- Frame length and inter-packet gap are programmable. Running counters report what was sent.

Parameters:
- DATA_WIDTH, 64: 64b block width.
- TC_WIDTH, 257: transcoded block width (4*DATA_WIDTH+1).
- DATA_CHAR_PATTERN, 8'hAA: value of every data byte.
- CTRL_CHAR_PATTERN, 7'h1E: value of every 7-bit control character.

Ports:
- clk  in  1  clock.
- i_rst  in  1  synchronous active-high reset.
- i_enable  in  1  allows new frames to start.
- i_frame_bytes  in  16  payload bytes per frame, sampled at frame start.
- i_ipg_blocks  in  8  idle 64b blocks between terminate and next start, sampled at frame start.
- i_ready  in  1  downstream accepts o_tx_coded.
- o_tx_coded  out  257  transcoded block.
- o_valid  out  1  o_tx_coded valid.
- o_block_count  out  32  257b blocks accepted.
- o_data_block_count  out  32  accepted blocks with bit0=1.
- o_ctrl_block_count  out  32  accepted blocks with bit0=0.
- o_frame_count  out  32  terminate blocks accepted.

Behaviour:
- Reset (synchronous, i_rst=1 at clk edge):
  - All outputs 0. Sequencer goes to IDLE with the gap counter at 0.
  - Reset mid-frame abandons the frame with no terminate and no count.
- Output register:
  - Loads only when (!o_valid || i_ready).
  - o_valid=1 from the first cycle after reset release and stays 1.
  - While o_valid && !i_ready, o_tx_coded and all counters hold.
  - Counters increment on o_valid && i_ready and wrap at 2^32.
- Lane sequencer:
  - Evaluated for lanes 0..3 in order within one cycle; lane 0 is earliest in time.
  - States: IDLE, START, DATA, TERM.
  - IDLE emits idle blocks. When the gap counter is 0 and i_enable=1, the next lane becomes START and latches P=max(i_frame_bytes,7) and the gap value.
  - START carries 7 data bytes. R=P-7.
  - DATA emits R/8 full data blocks.
  - TERM is terminate T_k with k=R%8 data bytes.
  - After TERM, the sequencer emits the latched gap count of idle blocks (0 allowed: the next lane may be START).
  - A frame may span any number of 257b blocks. START and TERM may share one block.
- 64b block types. Type byte / nibble = high nibble of the type byte:
  - Idle: 0x1E / 4'h1. Payload {8{CTRL}}.
  - Start: 0x78 / 4'h7. Payload {7{DATA}}.
  - T_k: 0x87,0x99,0xAA,0xB4,0xCC,0xD2,0xE1,0xFF / 4'h8..4'hF.
  - T_k payload, LSB first: k data bytes, then (7-k) zero bits, then (7-k) CTRL chars.
- Transcoding:
  - All four lanes data: bit0=1, [256:1] = lanes concatenated, lane0 at LSB.
  - Otherwise:
    - bit0=0, and bit[1+i]=1 iff lane i is data.
    - Data lanes before the first control lane sit at [5+64i +:64].
    - The first control lane puts its nibble at [5+64i +:4] and its 56b payload at [9+64i +:56].
    - Every later lane sits at [1+64i +:64]: data as {8{DATA}}, control as {payload56, type8}.
- i_enable deasserted mid-frame: the current frame completes. Only new starts are blocked.

Test Plan:
- Release reset, i_enable=1, P=7, ipg=2 -> first block:
  - bit0=0, [4:1]=0, [8:5]=4'h7, [64:9]={7{AA}}.
  - [72:65]=8'h87, [79:73]=0, [128:80]={7{1E}}.
  - Lanes 2-3 idle (0x1E+{8{1E}}). o_frame_count=1 after acceptance.
- P=39, ipg=4 -> block0 = S D D D (bit0=0, [4:1]=4'b1110); block1 = D T0 I I ([4:1]=4'b0001, [72:69]=4'h8).
- P=71 -> second block bit0=1, [256:1]={32{AA}}; o_data_block_count=1.
- P=3 (clamped to 7), ipg=0 -> continuous S T0 S T0; 2 frames per block.
- Hold i_ready=0 for 3 cycles mid-frame -> o_tx_coded and counters frozen, and resume with no skipped block.
- Assert i_rst for 1 cycle mid-DATA -> all outputs 0 the next cycle; the next block is an idle or start sequence.

Source files
------------

// File: rtl/baser_257b_generator.sv
// baser_257b_generator: 64b frame sequencer (4 lanes/cycle) transcoded into 257b blocks on a valid/ready output.
module baser_257b_generator #(
   parameter int          DATA_WIDTH        = 64,
   parameter int          TC_WIDTH          = 257,
   parameter logic [7:0]  DATA_CHAR_PATTERN = 8'hAA,
   parameter logic [6:0]  CTRL_CHAR_PATTERN = 7'h1E
) (
   input  logic                clk,
   input  logic                i_rst,
   input  logic                i_enable,
   input  logic [15:0]         i_frame_bytes,
   input  logic [7:0]          i_ipg_blocks,
   input  logic                i_ready,
   output logic [TC_WIDTH-1:0] o_tx_coded,
   output logic                o_valid,
   output logic [31:0]         o_block_count,
   output logic [31:0]         o_data_block_count,
   output logic [31:0]         o_ctrl_block_count,
   output logic [31:0]         o_frame_count
);
   localparam logic [63:0] T_TYPES = 64'hFFE1D2CCB4AA9987;
   localparam logic [55:0] DATA56  = {7{DATA_CHAR_PATTERN}};
   localparam logic [55:0] CTRL56  = {8{CTRL_CHAR_PATTERN}};
   typedef enum logic [1:0] {IDLE, START, DATA, TERM} ph_t;
   ph_t                   ph, ph_n;
   logic [7:0]            gap, gap_n, ipg, ipg_n;
   logic [15:0]           nd, nd_n, r;
   logic [2:0]            k, k_n, nterm, nterm_q;
   logic [3:0]            dat;
   logic                  seen;
   logic [DATA_WIDTH-1:0] blk [4];
   logic [TC_WIDTH-1:0]   coded;
   always_comb begin
      ph_n = ph;
      gap_n = gap;
      ipg_n = ipg;
      nd_n = nd;
      k_n = k;
      r = '0;
      dat = '0;
      nterm = '0;
      for (int i = 0; i < 4; i++) begin
         blk[i] = {CTRL56, 8'h1E};
         if (ph_n == IDLE && gap_n == 8'd0 && i_enable) begin
            r = ((i_frame_bytes < 16'd7) ? 16'd7 : i_frame_bytes) - 16'd7;
            nd_n = {3'b000, r[15:3]};
            k_n = r[2:0];
            ipg_n = i_ipg_blocks;
            blk[i] = {DATA56, 8'h78};
            ph_n = (r[15:3] != 13'd0) ? DATA : TERM;
         end else if (ph_n == IDLE || ph_n == START) begin
            gap_n = (gap_n == 8'd0) ? 8'd0 : gap_n - 8'd1;
         end else if (ph_n == DATA) begin
            blk[i] = {8{DATA_CHAR_PATTERN}};
            dat[i] = 1'b1;
            ph_n = (nd_n == 16'd1) ? TERM : DATA;
            nd_n = nd_n - 16'd1;
         end else begin
            // k data bytes low, then zero pad, then control chars fill the top
            blk[i] = {(DATA56 & ((56'd1 << {k_n, 3'b000}) - 56'd1)) | (CTRL56 << (7 * k_n + 7)),
                      T_TYPES[8*k_n +: 8]};
            nterm = nterm + 3'd1;
            gap_n = ipg_n;
            ph_n = IDLE;
         end
      end
   end
   always_comb begin
      coded = '0;
      seen = 1'b0;
      if (&dat) begin
         coded = {blk[3], blk[2], blk[1], blk[0], 1'b1};
      end else begin
         coded[4:1] = dat;
         for (int i = 0; i < 3; i++) begin
            if (!seen && dat[i]) begin
               coded[5+64*i +: 64] = blk[i];
            end else if (!seen) begin
               coded[5+64*i +: 4] = blk[i][7:4];
               coded[9+64*i +: 56] = blk[i][63:8];
               seen = 1'b1;
            end else begin
               coded[1+64*i +: 64] = blk[i];
            end
         end
         if (!seen) begin
            coded[200:197] = blk[3][7:4];
            coded[256:201] = blk[3][63:8];
         end else begin
            coded[256:193] = blk[3];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (i_rst) begin
         ph <= IDLE;
         gap <= '0;
         ipg <= '0;
         nd <= '0;
         k <= '0;
         nterm_q <= '0;
         o_valid <= 1'b0;
         o_tx_coded <= '0;
         o_block_count <= '0;
         o_data_block_count <= '0;
         o_ctrl_block_count <= '0;
         o_frame_count <= '0;
      end else begin
         if (o_valid && i_ready) begin
            o_block_count <= o_block_count + 32'd1;
            o_data_block_count <= o_data_block_count + {31'd0, o_tx_coded[0]};
            o_ctrl_block_count <= o_ctrl_block_count + {31'd0, !o_tx_coded[0]};
            o_frame_count <= o_frame_count + {29'd0, nterm_q};
         end
         if (!o_valid || i_ready) begin
            o_valid <= 1'b1;
            o_tx_coded <= coded;
            nterm_q <= nterm;
            ph <= ph_n;
            gap <= gap_n;
            ipg <= ipg_n;
            nd <= nd_n;
            k <= k_n;
         end
      end
   end
endmodule

// File: tb/tb_baser_257b_generator.sv
// tb_baser_257b_generator: random traffic settings checked against a frame-level lane-queue model.
module tb_baser_257b_generator;
   logic         clk = 1'b0;
   logic         i_rst = 1'b1, i_enable = 1'b1, i_ready = 1'b1;
   logic [15:0]  i_frame_bytes = 16'd7;
   logic [7:0]   i_ipg_blocks = 8'd2;
   logic [256:0] o_tx_coded;
   logic         o_valid;
   logic [31:0]  o_block_count, o_data_block_count, o_ctrl_block_count, o_frame_count;
   baser_257b_generator dut (
      .clk(clk), .i_rst(i_rst), .i_enable(i_enable), .i_frame_bytes(i_frame_bytes),
      .i_ipg_blocks(i_ipg_blocks), .i_ready(i_ready), .o_tx_coded(o_tx_coded), .o_valid(o_valid),
      .o_block_count(o_block_count), .o_data_block_count(o_data_block_count),
      .o_ctrl_block_count(o_ctrl_block_count), .o_frame_count(o_frame_count)
   );
   always #5 clk = ~clk;
   int           n_tests = 0, n_fail = 0;
   int           q[$];
   int           kd[4];
   logic [256:0] e_coded = '0;
   logic         e_valid = 1'b0;
   logic [31:0]  e_blk = 0, e_dat = 0, e_ctl = 0, e_frm = 0;
   int           e_nterm = 0;
   // lane kinds: -1 idle, -2 start, -3 data, 0..7 terminate with k data bytes
   task automatic check(string tag, logic [256:0] got, logic [256:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] lane(int kind);
      logic [7:0]  d = 8'hAA;
      logic [6:0]  c = 7'h1E;
      logic [63:0] tt = 64'hFFE1D2CCB4AA9987;
      logic [63:0] b = '0;
      if (kind == -3) return {8{d}};
      if (kind == -2) return {{7{d}}, 8'h78};
      if (kind == -1) return {{8{c}}, 8'h1E};
      b[7:0] = tt[8*kind +: 8];
      for (int j = 0; j < 56; j++)
         if (j < 8 * kind) b[8+j] = d[j%8];
         else if (j >= 7 * kind + 7) b[8+j] = c[(j-7*kind-7)%7];
      return b;
   endfunction
   function automatic logic [256:0] xcode(input int k4[4]);
      logic [256:0] v = '0;
      logic [63:0]  l;
      int           pos = 5;
      bit           first = 1, all = 1;
      for (int i = 0; i < 4; i++) all &= (k4[i] == -3);
      if (all) begin
         for (int i = 0; i < 4; i++) v[1+64*i +: 64] = lane(k4[i]);
         v[0] = 1'b1;
         return v;
      end
      for (int i = 0; i < 4; i++) begin
         l = lane(k4[i]);
         v[1+i] = (k4[i] == -3);
         if (k4[i] == -3 && first) begin
            v[pos +: 64] = l;
            pos += 64;
         end else if (first) begin
            v[pos +: 4] = l[7:4];
            v[pos+4 +: 56] = l[63:8];
            pos += 60;
            first = 0;
         end else begin
            v[pos +: 64] = l;
            pos += 64;
         end
      end
      return v;
   endfunction
   task automatic expand_frame();
      int p, rr;
      p = (i_frame_bytes < 7) ? 7 : int'(i_frame_bytes);
      rr = p - 7;
      q.push_back(-2);
      repeat (rr / 8) q.push_back(-3);
      q.push_back(rr % 8);
      repeat (int'(i_ipg_blocks)) q.push_back(-1);
   endtask
   task automatic tick();
      @(posedge clk);
      if (i_rst) begin
         q.delete();
         e_valid = 0; e_coded = '0; e_nterm = 0;
         e_blk = 0; e_dat = 0; e_ctl = 0; e_frm = 0;
      end else begin
         if (e_valid && i_ready) begin
            e_blk++;
            if (e_coded[0]) e_dat++; else e_ctl++;
            e_frm += 32'(e_nterm);
         end
         if (!e_valid || i_ready) begin
            e_nterm = 0;
            for (int i = 0; i < 4; i++) begin
               if (q.size() == 0) begin
                  if (i_enable) expand_frame(); else q.push_back(-1);
               end
               kd[i] = q.pop_front();
               if (kd[i] >= 0) e_nterm++;
            end
            e_coded = xcode(kd);
            e_valid = 1;
         end
      end
      #1;
      check("valid", o_valid, e_valid);
      check("coded", o_tx_coded, e_coded);
      check("blocks", o_block_count, e_blk);
      check("data_blocks", o_data_block_count, e_dat);
      check("ctrl_blocks", o_ctrl_block_count, e_ctl);
      check("frames", o_frame_count, e_frm);
   endtask
   initial begin
      tick();
      i_rst = 0;
      tick();
      check("start_nibble", o_tx_coded[8:5], 4'h7);
      check("t0_type", o_tx_coded[72:65], 8'h87);
      check("t0_ctrl", o_tx_coded[128:80], {7{7'h1E}});
      tick();
      check("first_frame", o_frame_count, 32'd1);
      i_frame_bytes = 16'd39; i_ipg_blocks = 8'd4;
      repeat (6) tick();
      i_frame_bytes = 16'd71;
      repeat (8) tick();
      i_frame_bytes = 16'd3; i_ipg_blocks = 8'd0;
      repeat (6) tick();
      i_frame_bytes = 16'd200;
      repeat (4) tick();
      i_ready = 0;
      repeat (3) tick();
      i_ready = 1;
      repeat (3) tick();
      i_rst = 1;
      tick();
      i_rst = 0;
      repeat (4) tick();
      for (int n = 0; n < 3000; n++) begin
         i_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) begin
            i_frame_bytes = $urandom_range(0, 1) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 400));
            i_ipg_blocks = 8'($urandom_range(0, 6));
         end
         if ($urandom_range(0, 31) == 0) i_enable = ($urandom_range(0, 3) != 0);
         i_rst = ($urandom_range(0, 299) == 0);
         tick();
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
